// File: rtl/alu_issue_pkg.sv
// Shared constants, instruction layout and opcode mapping for the ALU issue stage.
package alu_issue_pkg;

    localparam int unsigned DEF_WIDTH    = 32;
    localparam int unsigned DEF_OP_WIDTH = 5;
    localparam int unsigned DEF_REG_ADDR = 5;

    // ALU opcodes, laid out as {alt, funct3, 1'b1}
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b10001;
    localparam logic [4:0] ALU_SLL  = 5'b00011;
    localparam logic [4:0] ALU_SLT  = 5'b00101;
    localparam logic [4:0] ALU_SLTU = 5'b00111;
    localparam logic [4:0] ALU_XOR  = 5'b01001;
    localparam logic [4:0] ALU_SRL  = 5'b01011;
    localparam logic [4:0] ALU_SRA  = 5'b11011;
    localparam logic [4:0] ALU_OR   = 5'b01101;
    localparam logic [4:0] ALU_AND  = 5'b01111;

    // RV32I major opcodes handled by this stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // RV32I R/I-type field layout
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv_instr_t;

    // Map funct3 plus the alternate-encoding bit to an ALU opcode
    function automatic logic [4:0] alu_op(input logic alt, input logic [2:0] funct3);
        logic [4:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: two write-first combinational reads, one sync write, x0 hardwired.
module alu_issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned REG_ADDR = DEF_REG_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_ADDR-1:0] raddr1,
    output logic [WIDTH-1:0]    rdata1_c,
    input  logic [REG_ADDR-1:0] raddr2,
    output logic [WIDTH-1:0]    rdata2_c,
    input  logic                we,
    input  logic [REG_ADDR-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata
);

    localparam int unsigned NREGS = 32'(1) << REG_ADDR;

    logic [WIDTH-1:0] mem [NREGS];

    // Storage update; writes to x0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports see a same-cycle write so issue never waits on the regfile
    always_comb begin
        rdata1_c = '0;
        rdata2_c = '0;
        if (raddr1 != '0) begin
            rdata1_c = (we && (waddr == raddr1)) ? wdata : mem[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2_c = (we && (waddr == raddr2)) ? wdata : mem[raddr2];
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: RV32I integer decode, operand read, hazard scoreboard, held ALU entry.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned OP_WIDTH = DEF_OP_WIDTH,
    parameter int unsigned REG_ADDR = DEF_REG_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [WIDTH-1:0]    in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OP_WIDTH-1:0] alu_opcode,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [REG_ADDR-1:0] out_rd,
    output logic                out_wb,
    output logic                out_illegal,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [REG_ADDR-1:0] wb_rd,
    input  logic [WIDTH-1:0]    wb_data
);

    localparam int unsigned NREGS = 32'(1) << REG_ADDR;

    rv_instr_t ins;
    assign ins = rv_instr_t'(in_instr);

    logic [REG_ADDR-1:0] rs1, rs2, rd;
    assign rs1 = REG_ADDR'(ins.rs1);
    assign rs2 = REG_ADDR'(ins.rs2);
    assign rd  = REG_ADDR'(ins.rd);

    logic [WIDTH-1:0] rs1_val, rs2_val;

    alu_issue_regfile #(
        .WIDTH    (WIDTH),
        .REG_ADDR (REG_ADDR)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr1   (rs1),
        .rdata1_c (rs1_val),
        .raddr2   (rs2),
        .rdata2_c (rs2_val),
        .we       (wb_en),
        .waddr    (wb_rd),
        .wdata    (wb_data)
    );

    logic [WIDTH-1:0] imm_i, imm_u, imm_shamt;
    assign imm_i     = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_u     = WIDTH'({in_instr[31:12], 12'b0});
    assign imm_shamt = WIDTH'(in_instr[24:20]);

    logic [OP_WIDTH-1:0] dec_op;
    logic [WIDTH-1:0]    dec_a, dec_b;
    logic                dec_legal, dec_wb, use_rs1, use_rs2;

    // Instruction decode and operand selection; illegal words collapse to a harmless ADD 0,0
    always_comb begin
        dec_op    = OP_WIDTH'(ALU_ADD);
        dec_a     = '0;
        dec_b     = '0;
        dec_legal = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (ins.opcode)
            OPC_OP: begin
                dec_legal = (ins.funct7 == F7_BASE) ||
                            ((ins.funct7 == F7_ALT) && ((ins.funct3 == 3'b000) || (ins.funct3 == 3'b101)));
                dec_op    = OP_WIDTH'(alu_op(ins.funct7[5], ins.funct3));
                dec_a     = rs1_val;
                dec_b     = rs2_val;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_a   = rs1_val;
                use_rs1 = 1'b1;
                case (ins.funct3)
                    3'b001: begin
                        dec_legal = (ins.funct7 == F7_BASE);
                        dec_op    = OP_WIDTH'(alu_op(1'b0, ins.funct3));
                        dec_b     = imm_shamt;
                    end
                    3'b101: begin
                        dec_legal = (ins.funct7 == F7_BASE) || (ins.funct7 == F7_ALT);
                        dec_op    = OP_WIDTH'(alu_op(ins.funct7[5], ins.funct3));
                        dec_b     = imm_shamt;
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_op    = OP_WIDTH'(alu_op(1'b0, ins.funct3));
                        dec_b     = imm_i;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_b     = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_a     = in_pc;
                dec_b     = imm_u;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
        if (!dec_legal) begin
            dec_op  = OP_WIDTH'(ALU_ADD);
            dec_a   = '0;
            dec_b   = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    assign dec_wb = dec_legal && (rd != '0);

    logic [NREGS-1:0] busy, busy_live, busy_nxt, wb_clr, flush_clr, acc_set;
    logic             hazard, accept;

    // Scoreboard view after this cycle's writeback; a retiring register no longer blocks issue
    always_comb begin
        wb_clr    = wb_en ? (NREGS'(1) << wb_rd) : '0;
        busy_live = busy & ~wb_clr;
        hazard    = (use_rs1 && busy_live[rs1]) ||
                    (use_rs2 && busy_live[rs2]) ||
                    (dec_wb  && busy_live[rd]);
        in_ready  = (!out_valid || out_ready) && !hazard && !flush;
        accept    = in_valid && in_ready;
        flush_clr = (flush && out_valid && out_wb) ? (NREGS'(1) << out_rd) : '0;
        acc_set   = (accept && dec_wb) ? (NREGS'(1) << rd) : '0;
        busy_nxt  = ((busy & ~wb_clr & ~flush_clr) | acc_set) & ~NREGS'(1);
    end

    // Held ALU entry and scoreboard state
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            alu_opcode  <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            out_rd      <= '0;
            out_wb      <= 1'b0;
            out_illegal <= 1'b0;
            busy        <= '0;
        end else begin
            busy <= busy_nxt;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                alu_opcode  <= dec_op;
                alu_a       <= dec_a;
                alu_b       <= dec_b;
                out_rd      <= rd;
                out_wb      <= dec_wb;
                out_illegal <= !dec_legal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Directed plus randomized bench for alu_issue against a behavioural issue-stage model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  out_rd;
    logic        out_wb;
    logic        out_illegal;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .out_rd      (out_rd),
        .out_wb      (out_wb),
        .out_illegal (out_illegal),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
        logic        use1;
        logic        use2;
    } ent_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_hv;
    ent_t        m_h;
    logic        obs_rdy;

    localparam logic [31:0] ADD3   = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] SUB3   = 32'h402081B3; // sub x3,x1,x2
    localparam logic [31:0] ADDI4  = 32'hFFF00213; // addi x4,x0,-1
    localparam logic [31:0] SRAI5  = 32'h4030D293; // srai x5,x1,3
    localparam logic [31:0] ADD4   = 32'h00118233; // add x4,x3,x1
    localparam logic [31:0] ADDI6  = 32'h00100313; // addi x6,x0,1
    localparam logic [31:0] ADDI7  = 32'h00018393; // addi x7,x3,0
    localparam logic [31:0] ADD8   = 32'h00000433; // add x8,x0,x0

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the held entry against literal values
    task automatic chk_ent(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic wb, input logic ill);
        chk({tag, "_valid"}, 128'(out_valid), 128'(1));
        chk(tag, {alu_opcode, alu_a, alu_b, out_rd, out_wb, out_illegal}, {op, a, b, rd, wb, ill});
    endtask

    // ALU opcode for the non-alternate form of each funct3, from the fixed encoding table
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return 5'b00001;
            3'd1:    return 5'b00011;
            3'd2:    return 5'b00101;
            3'd3:    return 5'b00111;
            3'd4:    return 5'b01001;
            3'd5:    return 5'b01011;
            3'd6:    return 5'b01101;
            default: return 5'b01111;
        endcase
    endfunction

    // Instruction -> expected ALU entry, given already-bypassed source values
    function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] v1, input logic [31:0] v2);
        ent_t       e;
        logic       legal;
        logic [6:0] f7;
        logic [2:0] f3;
        e     = '0;
        legal = 1'b0;
        f7    = ins[31:25];
        f3    = ins[14:12];
        e.rd  = ins[11:7];
        e.op  = 5'b00001;
        case (ins[6:0])
            7'h33: begin
                e.use1 = 1'b1; e.use2 = 1'b1; e.a = v1; e.b = v2;
                if (f7 == 7'h00) begin legal = 1'b1; e.op = base_op(f3); end
                else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1'b1; e.op = 5'b10001; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1'b1; e.op = 5'b11011; end
            end
            7'h13: begin
                e.use1 = 1'b1; e.a = v1;
                if (f3 == 3'd1) begin
                    legal = (f7 == 7'h00); e.op = 5'b00011; e.b = {27'b0, ins[24:20]};
                end else if (f3 == 3'd5) begin
                    e.b = {27'b0, ins[24:20]};
                    if (f7 == 7'h00) begin legal = 1'b1; e.op = 5'b01011; end
                    else if (f7 == 7'h20) begin legal = 1'b1; e.op = 5'b11011; end
                end else begin
                    legal = 1'b1; e.op = base_op(f3); e.b = {{20{ins[31]}}, ins[31:20]};
                end
            end
            7'h37: begin legal = 1'b1; e.a = 32'h0; e.b = {ins[31:12], 12'h000}; end
            7'h17: begin legal = 1'b1; e.a = pc;    e.b = {ins[31:12], 12'h000}; end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.op = 5'b00001; e.a = '0; e.b = '0; e.use1 = 1'b0; e.use2 = 1'b0;
        end
        e.ill = !legal;
        e.wb  = legal && (e.rd != 5'd0);
        return e;
    endfunction

    // One clock of stimulus: drive, predict, check in_ready, clock, check held entry
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic we,
                        input logic [4:0] wrd, input logic [31:0] wd);
        logic [31:0] rw [32];
        logic [31:0] bw;
        ent_t        d;
        logic        stall, exp_rdy;
        in_valid = v; in_instr = instr; in_pc = pc; out_ready = ordy;
        flush = fl; wb_en = we; wb_rd = wrd; wb_data = wd;
        rw = m_regs;
        if (we && wrd != 5'd0) rw[wrd] = wd;
        bw = m_busy;
        if (we) bw[wrd] = 1'b0;
        d = ref_decode(instr, pc, rw[instr[19:15]], rw[instr[24:20]]);
        stall = (d.use1 && bw[instr[19:15]]) || (d.use2 && bw[instr[24:20]]) || (d.wb && bw[d.rd]);
        exp_rdy = (!m_hv || ordy) && !stall && !fl;
        #1;
        obs_rdy = in_ready;
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        @(posedge clk);
        m_regs = rw;
        if (fl) begin
            if (m_hv && m_h.wb) bw[m_h.rd] = 1'b0;
            m_hv = 1'b0;
        end else if (v && exp_rdy) begin
            m_hv = 1'b1;
            m_h  = d;
            if (d.wb) bw[d.rd] = 1'b1;
        end else if (ordy) begin
            m_hv = 1'b0;
        end
        m_busy = bw;
        #1;
        chk("out_valid", 128'(out_valid), 128'(m_hv));
        if (m_hv) begin
            chk("entry", {alu_opcode, alu_a, alu_b, out_wb, out_illegal, m_h.ill ? 5'd0 : out_rd},
                {m_h.op, m_h.a, m_h.b, m_h.wb, m_h.ill, m_h.ill ? 5'd0 : m_h.rd});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {out_valid, alu_opcode, alu_a, alu_b, out_rd, out_wb, out_illegal}, 128'(0));
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        m_hv   = 1'b0;
        m_h    = '0;
    endtask

    function automatic logic [31:0] gen_instr(input int kind);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [31:0] r;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        r   = $urandom;
        case (kind)
            0, 1, 2, 3: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            4, 5: begin
                if (f3 == 3'd1)      imm = {7'h00, rs2};
                else if (f3 == 3'd5) imm = {(r[1] ? 7'h20 : 7'h00), rs2};
                else                 imm = r[31:20];
                return {imm, rs1, f3, rd, 7'h13};
            end
            6: return {r[31:12], rd, 7'h37};
            7: return {r[31:12], rd, 7'h17};
            8: return {7'($urandom_range(0, 127)), rs2, rs1, f3, rd, (r[2] ? 7'h33 : 7'h13)};
            default: return r;
        endcase
    endfunction

    initial begin
        do_reset();
        step(0, 32'h0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        chk("idle_ready", 128'(obs_rdy), 128'(1));

        // preload x1=5, x2=7
        step(0, 32'h0, 32'h0, 1, 0, 1, 5'd1, 32'd5);
        step(0, 32'h0, 32'h0, 1, 0, 1, 5'd2, 32'd7);

        step(1, ADD3, 32'h100, 1, 0, 0, 5'd0, 32'h0);
        chk_ent("add", 5'b00001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        step(1, SUB3, 32'h104, 1, 0, 1, 5'd3, 32'h11);
        chk_ent("sub", 5'b10001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        step(1, ADDI4, 32'h108, 1, 0, 0, 5'd0, 32'h0);
        chk_ent("addi", 5'b00001, 32'd0, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0);
        step(1, SRAI5, 32'h10C, 1, 0, 0, 5'd0, 32'h0);
        chk_ent("srai", 5'b11011, 32'd5, 32'd3, 5'd5, 1'b1, 1'b0);
        step(0, 32'h0, 32'h0, 1, 0, 1, 5'd3, 32'h11);
        step(0, 32'h0, 32'h0, 1, 0, 1, 5'd4, 32'h44);
        step(0, 32'h0, 32'h0, 1, 0, 1, 5'd5, 32'h55);

        // RAW on x3, released by a bypassed writeback
        step(1, ADD3, 32'h110, 1, 0, 0, 5'd0, 32'h0);
        step(1, ADD4, 32'h114, 1, 0, 0, 5'd0, 32'h0);
        chk("raw_stall0", 128'(obs_rdy), 128'(0));
        step(1, ADD4, 32'h114, 1, 0, 0, 5'd0, 32'h0);
        chk("raw_stall1", 128'(obs_rdy), 128'(0));
        step(1, ADD4, 32'h114, 1, 0, 1, 5'd3, 32'h2A);
        chk("raw_release", 128'(obs_rdy), 128'(1));
        chk_ent("raw_bypass", 5'b00001, 32'h2A, 32'd5, 5'd4, 1'b1, 1'b0);

        // backpressure: held entry stable, then next loads on the same edge
        for (int i = 0; i < 3; i++) begin
            step(1, ADDI6, 32'h118, 0, 0, 0, 5'd0, 32'h0);
            chk("bp_ready", 128'(obs_rdy), 128'(0));
            chk_ent("bp_hold", 5'b00001, 32'h2A, 32'd5, 5'd4, 1'b1, 1'b0);
        end
        step(1, ADDI6, 32'h118, 1, 0, 0, 5'd0, 32'h0);
        chk("bp_release", 128'(obs_rdy), 128'(1));
        chk_ent("bp_next", 5'b00001, 32'd0, 32'd1, 5'd6, 1'b1, 1'b0);

        // flush drops add x3 and frees x3
        step(1, ADD3, 32'h11C, 1, 0, 0, 5'd0, 32'h0);
        chk_ent("flush_src", 5'b00001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        step(0, 32'h0, 32'h0, 0, 1, 0, 5'd0, 32'h0);
        chk("flush_valid", 128'(out_valid), 128'(0));
        step(1, ADDI7, 32'h120, 1, 0, 0, 5'd0, 32'h0);
        chk("flush_nostall", 128'(obs_rdy), 128'(1));
        chk_ent("after_flush", 5'b00001, 32'h2A, 32'd0, 5'd7, 1'b1, 1'b0);

        // illegal word and x0 writes
        step(1, 32'h0000_0000, 32'h124, 1, 0, 0, 5'd0, 32'h0);
        chk_ent("illegal", 5'b00001, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        step(0, 32'h0, 32'h0, 1, 0, 1, 5'd0, 32'hFFFF);
        step(1, ADD8, 32'h128, 1, 0, 0, 5'd0, 32'h0);
        chk_ent("x0_read", 5'b00001, 32'd0, 32'd0, 5'd8, 1'b1, 1'b0);

        // reset while an entry is held and another is stalled
        step(1, ADD3, 32'h12C, 0, 0, 0, 5'd0, 32'h0);
        do_reset();
        step(0, 32'h0, 32'h0, 1, 0, 1, 5'd1, 32'h33);
        step(1, ADD3, 32'h130, 1, 0, 0, 5'd0, 32'h0);
        chk_ent("post_rst", 5'b00001, 32'h33, 32'd0, 5'd3, 1'b1, 1'b0);

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 3) != 0, gen_instr(int'($urandom_range(0, 9))), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage directly upstream of the ALU. Accepts one RV32I integer instruction per cycle and decodes it to the 5-bit ALU opcode.
- Reads operands from an internal register file and presents registered opcode/a/b/rd to the ALU with a valid/ready handshake.
- Owns architectural register writeback and a per-register busy scoreboard that stalls on RAW/WAW hazards.

Parameters:
WIDTH, 32, datapath width (ALU a/b/out)
OP_WIDTH, 5, ALU opcode width
REG_ADDR, 5, register index width (32 registers)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  fetch presents in_instr/in_pc
in_ready  out  1  stage accepts this cycle
in_instr  in  32  instruction word
in_pc  in  WIDTH  instruction address
out_valid  out  1  held entry valid toward ALU
out_ready  in  1  ALU/execute consumes entry
alu_opcode  out  OP_WIDTH  opcode driven to ALU
alu_a  out  WIDTH  ALU operand a
alu_b  out  WIDTH  ALU operand b
out_rd  out  REG_ADDR  destination register
out_wb  out  1  entry will write out_rd
out_illegal  out  1  entry was not a supported instruction
flush  in  1  discard held entry
wb_en  in  1  writeback strobe from downstream
wb_rd  in  REG_ADDR  writeback register
wb_data  in  WIDTH  writeback value

Behaviour:
- Reset: out_valid=0; alu_opcode, alu_a, alu_b, out_rd, out_wb, out_illegal = 0; all 32 registers = 0; all busy bits = 0.
- Opcode encoding: alu_opcode = {alt, funct3, 1'b1}. Fixed values: ADD 00001, SUB 10001, SLL 00011, SLT 00101, SLTU 00111, XOR 01001, SRL 01011, SRA 11011, OR 01101, AND 01111.
- OP (0110011): alt = instr[30] for funct3 000 and 101, else 0. a = x[rs1], b = x[rs2].
- OP-IMM (0010011): b = sign-extended imm[11:0]. For shifts, b = zero-extended shamt; alt = instr[30] only for funct3 101. ADDI never yields SUB.
- LUI: opcode ADD, a = 0, b = {imm[31:12], 12'b0}.
- AUIPC: opcode ADD, a = in_pc, b = {imm[31:12], 12'b0}.
- Any other opcode, or a bad funct7 (not 0000000 / 0100000 where legal): out_illegal=1, out_wb=0, opcode ADD, a = b = 0.
- out_wb = 1 iff legal and rd != 0.
- Accept condition: in_valid && in_ready. in_ready = (!out_valid || out_ready) && !hazard && !flush.
- hazard: busy[rs1] (if used), busy[rs2] (if used), or busy[rd] (if out_wb), unless that register is being written by wb_en this cycle. x0 is never busy.
- On accept: output register loads the decoded entry the next edge (latency 1); busy[rd] set if out_wb.
- Entry consumed on out_valid && out_ready with no new accept: out_valid -> 0.
- Operand read is write-first: if wb_en && wb_rd == rs && rs != 0, wb_data is used in the same cycle.
- Register file: write on wb_en when wb_rd != 0; x0 reads 0; wb_en to x0 ignored. wb_en also clears busy[wb_rd].
- Busy set and clear to the same register in one cycle: set wins.
- flush: next edge out_valid=0. busy[out_rd] cleared if the held entry had out_wb. No accept that cycle. Regfile writes still occur.
- Reset mid-stream: held entry dropped; registers and busy cleared; pending writebacks after reset are still applied normally.
- out_* stay stable while out_valid && !out_ready.

Decomposition:
- Shared package: ALU opcode constants (names above), RV32I major opcodes (OP, OP_IMM, LUI, AUIPC), WIDTH/OP_WIDTH defaults.
- Sub-module regfile: 32xWIDTH, two combinational write-first read ports, one sync write port, x0 hardwired, sync reset.

Test Plan:
- Preload x1=5, x2=7 via wb. add x3,x1,x2 (0x002081B3) -> one cycle later out_valid=1, alu_opcode=00001, a=5, b=7, out_rd=3, out_wb=1.
- sub x3,x1,x2 (0x402081B3) -> alu_opcode=10001. addi x4,x0,-1 (0xFFF00213) -> opcode 00001, a=0, b=0xFFFFFFFF. srai x5,x1,3 (0x4030D293) -> opcode 11011, a=5, b=3.
- RAW: issue 0x002081B3, then add x4,x3,x1 (0x00118233) -> in_ready=0 until wb_en rd=3 data=0x2A. Accepted that same cycle with a=0x2A (bypass), b=5.
- Backpressure: hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Raise out_ready -> next instruction is loaded on the same edge.
- flush while holding add x3 -> out_valid=0 next cycle and busy[3] cleared. A subsequent read of x3 issues without stall.
- Instruction 0x00000000 -> out_illegal=1, out_wb=0, no busy set. wb_en rd=0 data=0xFFFF -> later reads of x0 give 0.
